// File: rtl/apb_pkg.sv
// Shared encodings for the APB SRAM arbiter: FSM states and requester port indices.
package apb_pkg;

  typedef enum logic [2:0] {
    APB_IDLE   = 3'b001,
    APB_SETUP  = 3'b010,
    APB_ACCESS = 3'b100
  } apb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // One-hot two-way grant to port index.
  function automatic logic gnt_idx(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way arbiter. Round-robin when APB_ARB_RR_EN is defined, else fixed priority m1 over m0.
module arb_rr2
  import apb_pkg::*;
(
  input  logic       pclk,
  input  logic       prstn,
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       valid
);

  assign valid = |req;

`ifdef APB_ARB_RR_EN
  logic last_q;

  // Reset to m1 so m0 wins the first tie.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      last_q <= ARB_M1;
    end else if (upd) begin
      last_q <= last_gnt;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == ARB_M1) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{pclk, prstn, last_gnt, upd};

  always_comb begin
    gnt = 2'b00;
    if (req[1]) begin
      gnt = 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/apb_sram_arb.sv
// Shares one APB SRAM slave between two req/done masters (m0 fetch, m1 data).
// Arbitration policy selected by APB_ARB_RR_EN (round-robin) or fixed m1-first when undefined.
module apb_sram_arb
  import apb_pkg::*;
#(
  parameter int unsigned N_WIDTH = 32,
  parameter int unsigned N_ADDR  = 10
) (
  input  logic               pclk,
  input  logic               prstn,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [N_ADDR-1:0]  m0_addr,
  input  logic [N_WIDTH-1:0] m0_wdata,
  output logic               m0_done,
  output logic [N_WIDTH-1:0] m0_rdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [N_ADDR-1:0]  m1_addr,
  input  logic [N_WIDTH-1:0] m1_wdata,
  output logic               m1_done,
  output logic [N_WIDTH-1:0] m1_rdata,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [N_ADDR-1:0]  paddr,
  output logic [N_WIDTH-1:0] pwdata,
  input  logic               pready,
  input  logic [N_WIDTH-1:0] prdata
);

  apb_state_e         state_q;
  logic               gnt_q;
  logic [1:0]         elig;
  logic [1:0]         arb_gnt;
  logic               arb_valid;
  logic               win_idx;
  logic               win_we;
  logic [N_ADDR-1:0]  win_addr;
  logic [N_WIDTH-1:0] win_wdata;
  logic               xfer_end;

  // A port completing this cycle still shows its old req; ignore it until next cycle.
  assign elig     = {m1_req & ~m1_done, m0_req & ~m0_done};
  assign xfer_end = (state_q == APB_ACCESS) && pready;

  arb_rr2 u_arb (
    .pclk     (pclk),
    .prstn    (prstn),
    .req      (elig),
    .last_gnt (gnt_q),
    .upd      (xfer_end),
    .gnt      (arb_gnt),
    .valid    (arb_valid)
  );

  assign win_idx = gnt_idx(arb_gnt);

  always_comb begin
    win_we    = m0_we;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (win_idx == ARB_M1) begin
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q  <= APB_IDLE;
      gnt_q    <= ARB_M0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      unique case (state_q)
        APB_IDLE: begin
          if (arb_valid) begin
            state_q <= APB_SETUP;
            gnt_q   <= win_idx;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= win_we;
            paddr   <= win_addr;
            pwdata  <= win_wdata;
          end
        end
        APB_SETUP: begin
          state_q <= APB_ACCESS;
          penable <= 1'b1;
        end
        APB_ACCESS: begin
          if (pready) begin
            state_q <= APB_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            if (gnt_q == ARB_M1) begin
              m1_done <= 1'b1;
              if (!pwrite) m1_rdata <= prdata;
            end else begin
              m0_done <= 1'b1;
              if (!pwrite) m0_rdata <= prdata;
            end
          end
        end
        default: begin
          state_q <= APB_IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_sram_arb.sv
// Directed bench for apb_sram_arb with a behavioural APB SRAM slave and programmable wait states.
module tb_apb_sram_arb;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        prstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        psel, penable, pwrite, pready;
  logic [9:0]  paddr;
  logic [31:0] pwdata, prdata;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_sram_arb dut (
    .pclk     (pclk),
    .prstn    (prstn),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_done  (m0_done),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_done  (m1_done),
    .m1_rdata (m1_rdata),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata)
  );

  // SRAM slave: stall count loaded in SETUP, counted down in ACCESS.
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;
  int          stall = 0;
  int          stall_load = 0;

  assign pready = penable && (stall == 0);
  assign prdata = mem[paddr[9:2]];

  always @(posedge pclk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]   <= 32'h0000_00A5;
      mem[5]   <= 32'h5A5A_0014;
      mem_init <= 1'b1;
    end else if (psel && penable && pready && pwrite) begin
      mem[paddr[9:2]] <= pwdata;
    end
    if (psel && !penable) stall <= stall_load;
    else if (psel && penable && stall > 0) stall <= stall - 1;
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          nwait;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] exp_rd [2];

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [9:0] addr, input logic [31:0] wdata);
    if (port == ARB_M1) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic chk_rdata();
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
  endtask

  task automatic xfer(input vec_t v);
    stall_load = v.nwait;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    step();
    chk("setup_ctl", {30'b0, psel, penable}, 32'b10);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", pwrite, v.we);
    for (int i = 0; i <= v.nwait; i++) begin
      step();
      chk("access_ctl", {30'b0, psel, penable}, 32'b11);
      chk("access_paddr", paddr, v.addr);
      chk("access_pwrite", pwrite, v.we);
      chk("access_pwdata", pwdata, v.wdata);
      chk("access_no_done", {m1_done, m0_done}, 2'b00);
    end
    step();
    if (!v.we) exp_rd[v.port] = v.exp_rdata;
    chk("done", {m1_done, m0_done}, (v.port == ARB_M1) ? 2'b10 : 2'b01);
    chk_rdata();
    chk("idle_ctl", {30'b0, psel, penable}, 32'b00);
    drive(v.port, 1'b0, 1'b0, 10'h0, 32'h0);
    step();
    chk("post_done", {m1_done, m0_done}, 2'b00);
  endtask

  initial begin
    logic       first;
    logic       second;
    logic [9:0] a_first, a_second;

    vecs[0] = '{ARB_M0, 1'b0, 10'h010, 32'h0,         0, 32'h0000_00A5};
    vecs[1] = '{ARB_M1, 1'b1, 10'h3FC, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[2] = '{ARB_M1, 1'b0, 10'h3FC, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[3] = '{ARB_M0, 1'b1, 10'h020, 32'h1234_5678, 2, 32'h0};
    vecs[4] = '{ARB_M0, 1'b0, 10'h020, 32'h0,         1, 32'h1234_5678};
    vecs[5] = '{ARB_M1, 1'b0, 10'h010, 32'h0,         0, 32'h0000_00A5};
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;

    prstn = 1'b1;
    drive(ARB_M0, 1'b0, 1'b0, 10'h0, 32'h0);
    drive(ARB_M1, 1'b0, 1'b0, 10'h0, 32'h0);
    #1 prstn = 1'b0;
    #1;
    chk("rst_ctl", {29'b0, psel, penable, pwrite}, 32'b0);
    chk("rst_paddr", paddr, 10'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_done", {m1_done, m0_done}, 2'b00);
    chk_rdata();
    step();
    step();
    prstn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) xfer(vecs[i]);

    // Simultaneous continuous requests: the tie winner depends on policy, then masking alternates.
`ifdef APB_ARB_RR_EN
    first = ARB_M0;
`else
    first = ARB_M1;
`endif
    second   = ~first;
    a_first  = (first == ARB_M1) ? 10'h014 : 10'h010;
    a_second = (first == ARB_M1) ? 10'h010 : 10'h014;
    stall_load = 0;
    drive(ARB_M0, 1'b1, 1'b0, 10'h010, 32'h0);
    drive(ARB_M1, 1'b1, 1'b0, 10'h014, 32'h0);
    step();
    chk("tie_paddr1", paddr, a_first);
    step();
    step();
    exp_rd[first] = (first == ARB_M1) ? 32'h5A5A_0014 : 32'h0000_00A5;
    chk("tie_done1", {m1_done, m0_done}, (first == ARB_M1) ? 2'b10 : 2'b01);
    chk_rdata();
    step();
    chk("tie_setup2", {30'b0, psel, penable}, 32'b10);
    chk("tie_paddr2", paddr, a_second);
    step();
    step();
    exp_rd[second] = (second == ARB_M1) ? 32'h5A5A_0014 : 32'h0000_00A5;
    chk("tie_done2", {m1_done, m0_done}, (second == ARB_M1) ? 2'b10 : 2'b01);
    chk_rdata();
    drive(second, 1'b0, 1'b0, 10'h0, 32'h0);
    step();
    chk("tie_paddr3", paddr, a_first);
    step();
    step();
    chk("tie_done3", {m1_done, m0_done}, (first == ARB_M1) ? 2'b10 : 2'b01);
    drive(first, 1'b0, 1'b0, 10'h0, 32'h0);
    step();

    // Back-to-back from m0: req held across done with a new address.
    drive(ARB_M0, 1'b1, 1'b0, 10'h010, 32'h0);
    step();
    step();
    step();
    exp_rd[0] = 32'h0000_00A5;
    chk("b2b_done1", {m1_done, m0_done}, 2'b01);
    chk_rdata();
    drive(ARB_M0, 1'b1, 1'b0, 10'h014, 32'h0);
    step();
    chk("b2b_no_dup", {30'b0, psel, penable}, 32'b00);
    step();
    chk("b2b_setup", {30'b0, psel, penable}, 32'b10);
    chk("b2b_paddr", paddr, 10'h014);
    step();
    step();
    exp_rd[0] = 32'h5A5A_0014;
    chk("b2b_done2", {m1_done, m0_done}, 2'b01);
    chk_rdata();
    drive(ARB_M0, 1'b0, 1'b0, 10'h0, 32'h0);
    step();

    // Reset asserted while the slave is stalling in ACCESS.
    stall_load = 5;
    drive(ARB_M1, 1'b1, 1'b1, 10'h018, 32'h7777_0018);
    step();
    step();
    step();
    chk("rst_mid_access", {30'b0, psel, penable}, 32'b11);
    #2 prstn = 1'b0;
    #1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    chk("rst_mid_ctl", {29'b0, psel, penable, pwrite}, 32'b0);
    chk("rst_mid_paddr", paddr, 10'h0);
    chk("rst_mid_pwdata", pwdata, 32'h0);
    chk("rst_mid_done", {m1_done, m0_done}, 2'b00);
    chk_rdata();
    drive(ARB_M1, 1'b0, 1'b0, 10'h0, 32'h0);
    step();
    prstn = 1'b1;
    step();
    chk("rst_no_done", {m1_done, m0_done}, 2'b00);
    xfer(vecs[2]);
    xfer(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
